// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Radix-2 shift-add
//               multiply and restoring divide, one step per cycle, with
//               valid/ready request and response handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  md_op_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  input  logic        flush_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o
);

  typedef logic [31:0] data_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [5:0] c_LAST_STEP = 6'd32;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_op;
  logic        r_neg_a;     // product / quotient must be negated
  logic        r_neg_b;     // remainder must be negated (dividend negative)
  logic [5:0]  r_cnt;
  data_t       r_hi;        // product high word / partial remainder
  data_t       r_lo;        // multiplier shifting out / dividend-quotient
  data_t       r_opnd;      // multiplicand / divisor magnitude
  data_t       r_result;

  logic        w_accept;
  logic        w_rs1_signed;
  logic        w_rs2_signed;
  logic        w_neg1;
  logic        w_neg2;
  data_t       w_mag1;
  data_t       w_mag2;
  logic        w_div0;
  logic        w_ovf;
  logic        w_special;
  data_t       w_special_res;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  data_t       w_div_sub;
  logic [63:0] w_prod;
  logic [63:0] w_prod_fix;
  data_t       w_quo_fix;
  data_t       w_rem_fix;
  data_t       w_fix_res;

  // Handshake flags come straight from the state register
  assign req_ready_o  = (r_state == S_IDLE);
  assign resp_valid_o = (r_state == S_DONE);
  assign resp_data_o  = r_result;
  assign w_accept     = req_valid_i && req_ready_o;

  // Operand signedness and magnitude extraction
  assign w_rs1_signed = (md_op_i == 3'b001) || (md_op_i == 3'b010) ||
                        (md_op_i == 3'b100) || (md_op_i == 3'b110);
  assign w_rs2_signed = (md_op_i == 3'b001) || (md_op_i == 3'b100) ||
                        (md_op_i == 3'b110);
  assign w_neg1 = w_rs1_signed && data1_i[31];
  assign w_neg2 = w_rs2_signed && data2_i[31];
  assign w_mag1 = w_neg1 ? (~data1_i + 32'd1) : data1_i;
  assign w_mag2 = w_neg2 ? (~data2_i + 32'd1) : data2_i;

  // Division corner cases are answered at acceptance without iterating
  assign w_div0 = md_op_i[2] && (data2_i == 32'd0);
  assign w_ovf  = md_op_i[2] && !md_op_i[0] && (data1_i == 32'h8000_0000) &&
                  (data2_i == 32'hFFFF_FFFF);
  assign w_special = w_div0 || w_ovf;
  assign w_special_res = w_div0 ? (md_op_i[1] ? data1_i : 32'hFFFF_FFFF)
                                : (md_op_i[1] ? 32'd0   : 32'h8000_0000);

  // Multiply step: conditional add into the high word, then shift right by one
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : 33'd0);

  // Restoring divide step: shift in the next dividend bit, trial subtract
  assign w_div_shift = {r_hi, r_lo[31]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_sub   = w_div_shift[31:0] - r_opnd;

  // Sign fix-up applied on the final cycle
  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg_a ? (~w_prod + 64'd1) : w_prod;
  assign w_quo_fix  = r_neg_a ? (~r_lo + 32'd1) : r_lo;
  assign w_rem_fix  = r_neg_b ? (~r_hi + 32'd1) : r_hi;
  assign w_fix_res  = r_op[2] ? (r_op[1] ? w_rem_fix : w_quo_fix)
                              : ((r_op[1:0] == 2'b00) ? w_prod_fix[31:0]
                                                      : w_prod_fix[63:32]);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; flush overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          if (w_special)       w_state_nxt = S_DONE;
          else if (md_op_i[2]) w_state_nxt = S_DIV;
          else                 w_state_nxt = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == c_LAST_STEP) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (resp_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_i) w_state_nxt = S_IDLE;
  end

  // Datapath: operand capture at acceptance, one iteration per busy cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op     <= 3'd0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_cnt    <= 6'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_opnd   <= 32'd0;
      r_result <= 32'd0;
    end else if (w_accept && !flush_i) begin
      r_op    <= md_op_i;
      r_neg_a <= w_neg1 ^ w_neg2;
      r_neg_b <= w_neg1;
      r_cnt   <= 6'd0;
      r_hi    <= 32'd0;
      r_lo    <= md_op_i[2] ? w_mag1 : w_mag2;
      r_opnd  <= md_op_i[2] ? w_mag2 : w_mag1;
      if (w_special) r_result <= w_special_res;
    end else if (((r_state == S_MUL) || (r_state == S_DIV)) && !flush_i) begin
      if (r_cnt != c_LAST_STEP) begin
        r_cnt <= r_cnt + 6'd1;
        if (r_state == S_MUL) begin
          r_hi <= w_mul_sum[32:1];
          r_lo <= {w_mul_sum[0], r_lo[31:1]};
        end else begin
          r_hi <= w_div_ge ? w_div_sub : w_div_shift[31:0];
          r_lo <= {r_lo[30:0], w_div_ge};
        end
      end else begin
        r_result <= w_fix_res;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit with an expected-result
//               queue filled at request time and drained at response time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  md_op_i = 3'd0;
  logic [31:0] data1_i = 32'd0;
  logic [31:0] data2_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_data_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  muldiv_unit dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .md_op_i      (md_op_i),
    .data1_i      (data1_i),
    .data2_i      (data2_i),
    .flush_i      (flush_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Present one request; scramble operands right after acceptance
  task automatic send(input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp,
                      input bit push);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    md_op_i     = op;
    data1_i     = a;
    data2_i     = b;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    md_op_i     = ~op;
    data1_i     = $urandom;
    data2_i     = $urandom;
    if (push) exp_q.push_back(exp);
  endtask

  // Count edges after acceptance until resp_valid_o, bounded
  task automatic wait_resp(output int n);
    n = 0;
    do begin
      @(posedge clk_i);
      #1;
      n++;
    end while (!resp_valid_o && n < 200);
  endtask

  // Consume the held response
  task automatic take();
    @(negedge clk_i);
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    resp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_data_o !== 32'd0) begin
      failures++;
      $display("FAIL reset_values got ready=%b valid=%b data=%h exp 1 0 00000000",
               req_ready_o, resp_valid_o, resp_data_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
    logic [31:0] as  [4] = '{32'h7, 32'h7, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h3};
    logic [31:0] es  [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    for (int i = 0; i < 4; i++) begin
      int n;
      logic [31:0] e;
      send(ops[i], as[i], bs[i], es[i], 1'b1);
      wait_resp(n);
      checks++;
      if (n !== 33 || resp_valid_o !== 1'b1) begin
        failures++;
        $display("FAIL mul_latency[%0d] got=%0d valid=%b exp=33", i, n, resp_valid_o);
      end
      e = exp_q.pop_front();
      checks++;
      if (resp_data_o !== e) begin
        failures++;
        $display("FAIL mul_result[%0d] got=%h exp=%h", i, resp_data_o, e);
      end
      take();
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [5] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100};
    logic [31:0] as  [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd20};
    logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'd2, 32'd7, 32'hFFFF_FFFA};
    logic [31:0] es  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd2, 32'hFFFF_FFFD};
    for (int i = 0; i < 5; i++) begin
      int n;
      logic [31:0] e;
      send(ops[i], as[i], bs[i], es[i], 1'b1);
      wait_resp(n);
      checks++;
      if (n !== 33 || resp_valid_o !== 1'b1) begin
        failures++;
        $display("FAIL div_latency[%0d] got=%0d valid=%b exp=33", i, n, resp_valid_o);
      end
      e = exp_q.pop_front();
      checks++;
      if (resp_data_o !== e) begin
        failures++;
        $display("FAIL div_result[%0d] got=%h exp=%h", i, resp_data_o, e);
      end
      take();
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] as  [4] = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] es  [4] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      int n;
      logic [31:0] e;
      send(ops[i], as[i], bs[i], es[i], 1'b1);
      wait_resp(n);
      checks++;
      if (n !== 1 || resp_valid_o !== 1'b1) begin
        failures++;
        $display("FAIL special_latency[%0d] got=%0d valid=%b exp=1", i, n, resp_valid_o);
      end
      e = exp_q.pop_front();
      checks++;
      if (resp_data_o !== e) begin
        failures++;
        $display("FAIL special_result[%0d] got=%h exp=%h", i, resp_data_o, e);
      end
      take();
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] e;
    send(3'b011, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 1'b1);
    wait_resp(n);
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (resp_valid_o !== 1'b1 || resp_data_o !== e || req_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold[%0d] got valid=%b data=%h ready=%b exp 1 %h 0",
                 i, resp_valid_o, resp_data_o, req_ready_o, e);
      end
      @(posedge clk_i);
      #1;
    end
    take();
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release got ready=%b valid=%b exp 1 0",
               req_ready_o, resp_valid_o);
    end
  endtask

  task automatic test_flush();
    int n;
    bit seen;
    logic [31:0] e;
    send(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0);
    repeat (15) @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle got ready=%b valid=%b exp 1 0", req_ready_o, resp_valid_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i);
      #1;
      if (resp_valid_o) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_response got valid_seen=%b exp 0", seen);
    end
    send(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b1);
    wait_resp(n);
    e = exp_q.pop_front();
    checks++;
    if (resp_valid_o !== 1'b1 || resp_data_o !== e) begin
      failures++;
      $display("FAIL flush_next_mulhsu got valid=%b data=%h exp 1 %h",
               resp_valid_o, resp_data_o, e);
    end
    take();
  endtask

  task automatic test_async_reset();
    bit seen;
    send(3'b100, 32'd1000, 32'd3, 32'd0, 1'b0);
    repeat (10) @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_data_o !== 32'd0) begin
      failures++;
      $display("FAIL async_reset got ready=%b valid=%b data=%h exp 1 0 00000000",
               req_ready_o, resp_valid_o, resp_data_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i);
      #1;
      if (resp_valid_o) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_no_stale got valid_seen=%b ready=%b exp 0 1", seen, req_ready_o);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
